avmm_page_arbiter: RTL and testbench
====================================

Name: avmm_page_arbiter

Overview:
- Shares one paged-memory Avalon-MM slave port between two requesters: m0 is the host BAR2 path, m1 is an internal requester (DMA/sequencer).
- Each requester carries its own page number. The arbiter forwards the granted requester's page with its command, so the page window stays coherent per transaction.
- Round-robin, burst-aware.
- One transaction outstanding at a time. The grant is held until the whole burst completes.

Parameters:
- AW, 16, word address width
- DW, 64, data width; byteenable width is DW/8
- MAX_BURST, 4, largest legal burstcount; BCW = $clog2(MAX_BURST)+1
- PAGE_COUNT, 4, number of pages; PCW = max(1, $clog2(PAGE_COUNT))

Ports:
Shared signals:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset

mN_* signals are instantiated once for N=0 and once for N=1:
- mN_address  in  AW  word address
- mN_page  in  PCW  page number for this requester
- mN_read  in  1  read request
- mN_write  in  1  write request
- mN_writedata  in  DW  write data
- mN_byteenable  in  DW/8  byte enables
- mN_burstcount  in  BCW  burst length
- mN_waitrequest  out  1  stall to requester
- mN_readdata  out  DW  read data
- mN_readdatavalid  out  1  read beat valid

Slave side:
- s_address  out  AW  forwarded address
- s_page  out  PCW  forwarded page
- s_read  out  1  forwarded read
- s_write  out  1  forwarded write
- s_writedata  out  DW  forwarded write data
- s_byteenable  out  DW/8  forwarded byte enables
- s_burstcount  out  BCW  forwarded burst length
- s_waitrequest  in  1  slave stall
- s_readdata  in  DW  slave read data
- s_readdatavalid  in  1  slave read beat valid

Behaviour:
Reset (synchronous, active-high):
- State = IDLE, last_grant = 1, beat counter = 0.
- s_read = s_write = 0.
- m0/m1_waitrequest = 1.
- m0/m1_readdatavalid = 0.

States:
- IDLE
  - No request: stay.
  - One requester asserting read|write: register grant to it; go to CMD next cycle.
  - Both requesting: grant the requester != last_grant.
  - Arbitration latency is 1 cycle. Nothing is forwarded in IDLE.
- CMD
  - Granted requester's command and page are driven combinationally to s_*.
  - mG_waitrequest = s_waitrequest. The non-granted requester's waitrequest = 1.
  - Beat counter loads the burstcount when the first beat is accepted (request high and s_waitrequest low). burstcount 0 is treated as 1.
  - Write accepted:
    - burstcount 1: go to IDLE.
    - Otherwise: go to WBURST with remaining = burstcount-1.
  - Read accepted: go to RWAIT with remaining = burstcount.
  - If both read and write are asserted, write wins and read is ignored.
- WBURST
  - Grant is locked and s_write follows mG_write.
  - Each accepted beat decrements the count.
  - Last beat accepted: go to IDLE and update last_grant.
  - The other requester stays stalled even if the granted one idles between beats.
- RWAIT
  - s_read = s_write = 0. Both waitrequests = 1.
  - s_readdatavalid/s_readdata are routed to the granted requester only. The other requester's readdatavalid = 0.
  - Each valid beat decrements the count. On the last beat go to IDLE and update last_grant.
  - Readdata to the non-granted requester is don't-care.

Other rules:
- last_grant updates only on transaction completion.
- A new request is considered in the cycle the FSM re-enters IDLE, so back-to-back transactions have a 1-cycle bubble.
- Reset mid-burst or mid-read: abandon the transaction and return to reset state. Late slave readdatavalid beats are dropped because the state is IDLE.
- s_readdatavalid arriving in IDLE/CMD/WBURST is dropped.
- Forwarded data and address are unregistered. Critical path is mN → s.

Test Plan:
1. Only m0 single read to page 2, address 0x10; slave returns 0xDEAD after 3 cycles → s_page=2, s_address=0x10, s_read=1 for exactly one accepted cycle; m0_readdatavalid=1 with 0xDEAD once; m1_readdatavalid stays 0.
2. m0 and m1 both assert write, burstcount 1, in the same cycle after reset → m0 wins first (last_grant=1 at reset); m1 is forwarded next, after a 1-cycle bubble; last_grant ends at 1.
3. m1 write burst of 4 with m0 requesting throughout; slave waitrequest high on beat 2 for 2 cycles → all 4 m1 beats forwarded in order; m0_waitrequest=1 throughout; m0 granted only after the 4th beat.
4. m0 read burst of 4; m1 writes during RWAIT → m1 stalled until all 4 readdatavalid beats reach m0; then m1 is granted.
5. Reset asserted during beat 2 of a 4-beat m1 write → next cycle s_write=0 and both waitrequests=1; a subsequent m0 request is granted normally.
6. burstcount=0 read from m1 → treated as 1 beat; FSM returns to IDLE after one readdatavalid.

Source files
------------

// File: rtl/avmm_page_arbiter_if.sv
// Paged Avalon-MM link: one requester-side or slave-side port of the page arbiter.
// A beat transfers when read or write is high and waitrequest is low; readdatavalid is a one-cycle strobe with no backpressure.
interface avmm_page_arbiter_if #(
    parameter int AW         = 16,
    parameter int DW         = 64,
    parameter int MAX_BURST  = 4,
    parameter int PAGE_COUNT = 4
);
    localparam int BCW = $clog2(MAX_BURST) + 1;
    localparam int PCW = (PAGE_COUNT > 1) ? $clog2(PAGE_COUNT) : 1;

    logic [AW-1:0]   address;
    logic [PCW-1:0]  page;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
    logic [BCW-1:0]  burstcount;
    logic            waitrequest;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;

    modport master (
        output address, page, read, write, writedata, byteenable, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, page, read, write, writedata, byteenable, burstcount,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avmm_page_arbiter.sv
// Two-requester round-robin arbiter in front of one paged Avalon-MM slave.
// One transaction outstanding; the grant is held until the whole burst (write beats or read returns) completes.
module avmm_page_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 64,
    parameter int MAX_BURST  = 4,
    parameter int PAGE_COUNT = 4
) (
    input  logic                clock,
    input  logic                reset,
    avmm_page_arbiter_if.slave  m0,
    avmm_page_arbiter_if.slave  m1,
    avmm_page_arbiter_if.master s,
    output logic [1:0]          dbg_state,
    output logic                dbg_grant,
    output logic                dbg_last_grant
);
    localparam int BCW = $clog2(MAX_BURST) + 1;
    localparam int PCW = (PAGE_COUNT > 1) ? $clog2(PAGE_COUNT) : 1;
    localparam logic [BCW-1:0] ONE_BEAT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        WBURST = 2'd2,
        RWAIT  = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic           grant, grant_nxt;
    logic           last_grant, last_grant_nxt;
    logic [BCW-1:0] remaining, remaining_nxt;

    logic           req0, req1;
    logic [AW-1:0]  g_address;
    logic [PCW-1:0] g_page;
    logic           g_read, g_write;
    logic [DW-1:0]  g_writedata;
    logic [DW/8-1:0] g_byteenable;
    logic [BCW-1:0] g_burstcount;
    logic [BCW-1:0] g_beats;
    logic           g_wait, g_rdv;
    logic           fwd_read, fwd_write;
    logic           cmd_accept;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // Granted requester's command, selected combinationally straight onto the slave bus.
    assign g_address    = grant ? m1.address    : m0.address;
    assign g_page       = grant ? m1.page       : m0.page;
    assign g_read       = grant ? m1.read       : m0.read;
    assign g_write      = grant ? m1.write      : m0.write;
    assign g_writedata  = grant ? m1.writedata  : m0.writedata;
    assign g_byteenable = grant ? m1.byteenable : m0.byteenable;
    assign g_burstcount = grant ? m1.burstcount : m0.burstcount;

    assign g_beats    = (g_burstcount == '0) ? ONE_BEAT : g_burstcount;
    assign cmd_accept = (g_read | g_write) & ~s.waitrequest;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            remaining  <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            remaining  <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        remaining_nxt  = remaining;
        fwd_read       = 1'b0;
        fwd_write      = 1'b0;
        g_wait         = 1'b1;
        g_rdv          = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_nxt = CMD;
                    if (req0 & req1) begin
                        grant_nxt = ~last_grant;
                    end else begin
                        grant_nxt = req1;
                    end
                end
            end
            CMD: begin
                // Write wins when both strobes are high; the read is simply not forwarded.
                fwd_write = g_write;
                fwd_read  = g_read & ~g_write;
                g_wait    = s.waitrequest;
                if (cmd_accept) begin
                    if (g_write) begin
                        if (g_beats == ONE_BEAT) begin
                            state_nxt      = IDLE;
                            last_grant_nxt = grant;
                        end else begin
                            state_nxt     = WBURST;
                            remaining_nxt = g_beats - ONE_BEAT;
                        end
                    end else begin
                        state_nxt     = RWAIT;
                        remaining_nxt = g_beats;
                    end
                end
            end
            WBURST: begin
                fwd_write = g_write;
                g_wait    = s.waitrequest;
                if (g_write & ~s.waitrequest) begin
                    remaining_nxt = remaining - ONE_BEAT;
                    if (remaining == ONE_BEAT) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = grant;
                    end
                end
            end
            RWAIT: begin
                g_rdv = s.readdatavalid;
                if (s.readdatavalid) begin
                    remaining_nxt = remaining - ONE_BEAT;
                    if (remaining == ONE_BEAT) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = grant;
                    end
                end
            end
        endcase
    end

    assign s.address    = g_address;
    assign s.page       = g_page;
    assign s.writedata  = g_writedata;
    assign s.byteenable = g_byteenable;
    assign s.burstcount = g_burstcount;
    assign s.read       = fwd_read;
    assign s.write      = fwd_write;

    // Non-granted requester always sees a stall and never sees a read strobe.
    assign m0.waitrequest   = grant ? 1'b1 : g_wait;
    assign m1.waitrequest   = grant ? g_wait : 1'b1;
    assign m0.readdatavalid = ~grant & g_rdv;
    assign m1.readdatavalid = grant & g_rdv;
    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;

    assign dbg_state      = state;
    assign dbg_grant      = grant;
    assign dbg_last_grant = last_grant;
endmodule

// File: tb/tb_avmm_page_arbiter.sv
// Directed bench for avmm_page_arbiter: transaction-level reference model checked every cycle,
// a write-beat scoreboard on the slave side and hand-computed literals per scenario.
module tb_avmm_page_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 64;
    localparam int BCW = 3;
    localparam int PCW = 2;
    localparam int W   = PCW + AW + DW/8 + DW;
    localparam int PH_FREE  = 0;
    localparam int PH_OFFER = 1;
    localparam int PH_WRITE = 2;
    localparam int PH_READ  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    avmm_page_arbiter_if m0_if ();
    avmm_page_arbiter_if m1_if ();
    avmm_page_arbiter_if s_if ();

    logic [AW-1:0]   m_addr[2];
    logic [PCW-1:0]  m_page[2];
    logic            m_read[2];
    logic            m_write[2];
    logic [DW-1:0]   m_wdata[2];
    logic [DW/8-1:0] m_be[2];
    logic [BCW-1:0]  m_bc[2];
    logic            m_wait[2];
    logic            m_rdv[2];
    logic [DW-1:0]   m_rdata[2];
    logic            s_wait;
    logic            s_rdv;
    logic [DW-1:0]   s_rd;
    logic [1:0]      dbg_state;
    logic            dbg_grant;
    logic            dbg_last_grant;

    assign m0_if.address = m_addr[0];   assign m1_if.address = m_addr[1];
    assign m0_if.page = m_page[0];      assign m1_if.page = m_page[1];
    assign m0_if.read = m_read[0];      assign m1_if.read = m_read[1];
    assign m0_if.write = m_write[0];    assign m1_if.write = m_write[1];
    assign m0_if.writedata = m_wdata[0]; assign m1_if.writedata = m_wdata[1];
    assign m0_if.byteenable = m_be[0];  assign m1_if.byteenable = m_be[1];
    assign m0_if.burstcount = m_bc[0];  assign m1_if.burstcount = m_bc[1];
    assign m_wait[0] = m0_if.waitrequest;     assign m_wait[1] = m1_if.waitrequest;
    assign m_rdv[0] = m0_if.readdatavalid;    assign m_rdv[1] = m1_if.readdatavalid;
    assign m_rdata[0] = m0_if.readdata;       assign m_rdata[1] = m1_if.readdata;
    assign s_if.waitrequest = s_wait;
    assign s_if.readdatavalid = s_rdv;
    assign s_if.readdata = s_rd;

    avmm_page_arbiter dut (
        .clock(clk), .reset(rst),
        .m0(m0_if), .m1(m1_if), .s(s_if),
        .dbg_state(dbg_state), .dbg_grant(dbg_grant), .dbg_last_grant(dbg_last_grant)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    logic [W-1:0] exp_q[$];
    int wr_cyc_q[$];
    int rd_cnt[2] = '{0, 0};
    logic [DW-1:0] last_rdata[2];
    int last_rdv_cyc[2] = '{0, 0};
    int s_rd_cycles = 0;
    int s_wr_beats = 0;
    logic [PCW-1:0] last_rd_page;
    logic [AW-1:0] last_rd_addr;
    int rsp_lat = 3;
    int rsp_extra = 0;
    logic [DW-1:0] rsp_base = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [DW/8-1:0] be_of(input logic [DW-1:0] d);
        return 8'hF0 ^ d[7:0];
    endfunction

    function automatic void push_write(input logic [PCW-1:0] pg, input logic [AW-1:0] a,
                                       input int beats, input logic [DW-1:0] d);
        for (int i = 0; i < beats; i++) exp_q.push_back({pg, a, be_of(d), d + DW'(i)});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester driver: holds the command until every beat is accepted, then drops it.
    task automatic run_req(input int n, input bit wr, input logic [AW-1:0] addr, input logic [PCW-1:0] pg,
                           input logic [BCW-1:0] bc, input logic [DW-1:0] dbase);
        int beats, done, budget;
        bit acc;
        beats = wr ? ((bc == 0) ? 1 : int'(bc)) : 1;
        done = 0;
        budget = 200;
        m_addr[n] = addr; m_page[n] = pg; m_bc[n] = bc; m_be[n] = be_of(dbase); m_wdata[n] = dbase;
        if (wr) m_write[n] = 1'b1; else m_read[n] = 1'b1;
        while (done < beats && budget > 0) begin
            @(negedge clk);
            acc = !m_wait[n];
            tick();
            budget--;
            if (acc) begin
                done++;
                m_wdata[n] = dbase + DW'(done);
            end
        end
        m_write[n] = 1'b0;
        m_read[n] = 1'b0;
        chk("req_beats_done", done, beats);
    endtask

    task automatic wait_rd(input int n, input int target);
        int budget;
        budget = 50;
        while (rd_cnt[n] < target && budget > 0) begin
            tick();
            budget--;
        end
        chk("rdv_arrived", rd_cnt[n] >= target, 1);
    endtask

    task automatic stall_after(input int target, input int cycles);
        int budget;
        budget = 100;
        while (s_wr_beats < target && budget > 0) begin
            tick();
            budget--;
        end
        chk("stall_trigger", s_wr_beats >= target, 1);
        s_wait = 1'b1;
        repeat (cycles) tick();
        s_wait = 1'b0;
    endtask

    // Slave read responder: burst of beats after rsp_lat cycles, data = rsp_base + beat index.
    int pend_beats = 0, pend_delay = 0, pend_idx = 0;
    initial begin
        s_rdv = 1'b0;
        s_rd = '0;
        forever begin
            @(negedge clk);
            if (chk_en && !rst && s_if.read && !s_wait) begin
                pend_beats = ((s_if.burstcount == 0) ? 1 : int'(s_if.burstcount)) + rsp_extra;
                pend_delay = rsp_lat;
                pend_idx = 0;
            end
            tick();
            s_rdv = 1'b0;
            if (pend_beats > 0) begin
                if (pend_delay > 1) pend_delay--;
                else begin
                    s_rdv = 1'b1;
                    s_rd = rsp_base + DW'(pend_idx);
                    pend_idx++;
                    pend_beats--;
                end
            end
        end
    end

    // Slave-side scoreboard for write beats and bookkeeping of reads.
    logic [W-1:0] got_w, exp_w;
    bit q_ok;
    always @(negedge clk) begin
        if (chk_en) begin
            if (s_if.write && !s_wait) begin
                s_wr_beats++;
                wr_cyc_q.push_back(cyc);
                got_w = {s_if.page, s_if.address, s_if.byteenable, s_if.writedata};
                q_ok = exp_q.size() > 0;
                chk("s_write_expected", q_ok, 1);
                if (q_ok) begin
                    exp_w = exp_q.pop_front();
                    chk("s_write_beat", got_w, exp_w);
                end
            end
            if (s_if.read) begin
                s_rd_cycles++;
                last_rd_page = s_if.page;
                last_rd_addr = s_if.address;
            end
            for (int n = 0; n < 2; n++) begin
                if (m_rdv[n]) begin
                    rd_cnt[n]++;
                    last_rdata[n] = m_rdata[n];
                    last_rdv_cyc[n] = cyc;
                end
            end
        end
    end

    // Transaction-level reference: who owns the slave and how many beats remain.
    int md_phase = PH_FREE, md_owner = 0, md_left = 0, md_last = 1;
    bit e_sr, e_sw;
    bit e_w[2];
    bit e_v[2];
    int o, nb;
    bit r0, r1;
    always @(negedge clk) begin
        if (chk_en) begin
            o = md_owner;
            e_sr = 0; e_sw = 0;
            e_w[0] = 1; e_w[1] = 1; e_v[0] = 0; e_v[1] = 0;
            if (md_phase == PH_OFFER) begin
                e_sw = m_write[o];
                e_sr = m_read[o] && !m_write[o];
                e_w[o] = s_wait;
            end else if (md_phase == PH_WRITE) begin
                e_sw = m_write[o];
                e_w[o] = s_wait;
            end else if (md_phase == PH_READ) begin
                e_v[o] = s_rdv;
            end
            chk("s_read", s_if.read, e_sr);
            chk("s_write", s_if.write, e_sw);
            chk("m0_waitrequest", m_wait[0], e_w[0]);
            chk("m1_waitrequest", m_wait[1], e_w[1]);
            chk("m0_readdatavalid", m_rdv[0], e_v[0]);
            chk("m1_readdatavalid", m_rdv[1], e_v[1]);
            chk("last_grant", dbg_last_grant, md_last);
            chk("idle_flag", dbg_state == 2'd0, md_phase == PH_FREE);
            if (e_sr || e_sw) begin
                chk("s_address", s_if.address, m_addr[o]);
                chk("s_page", s_if.page, m_page[o]);
                chk("s_byteenable", s_if.byteenable, m_be[o]);
                chk("s_burstcount", s_if.burstcount, m_bc[o]);
                if (e_sw) chk("s_writedata", s_if.writedata, m_wdata[o]);
            end
            for (int n = 0; n < 2; n++) if (e_v[n]) chk("m_readdata", m_rdata[n], s_rd);

            nb = (m_bc[o] == 0) ? 1 : int'(m_bc[o]);
            if (rst) begin
                md_phase = PH_FREE; md_last = 1; md_left = 0;
            end else if (md_phase == PH_FREE) begin
                r0 = m_read[0] || m_write[0];
                r1 = m_read[1] || m_write[1];
                if (r0 && r1) begin md_owner = 1 - md_last; md_phase = PH_OFFER; end
                else if (r0 || r1) begin md_owner = r1 ? 1 : 0; md_phase = PH_OFFER; end
            end else if (md_phase == PH_OFFER) begin
                if ((m_read[o] || m_write[o]) && !s_wait) begin
                    if (m_write[o] && nb == 1) begin md_phase = PH_FREE; md_last = o; end
                    else if (m_write[o]) begin md_phase = PH_WRITE; md_left = nb - 1; end
                    else begin md_phase = PH_READ; md_left = nb; end
                end
            end else if (md_phase == PH_WRITE) begin
                if (m_write[o] && !s_wait) md_left--;
                if (md_left == 0) begin md_phase = PH_FREE; md_last = o; end
            end else begin
                if (s_rdv) md_left--;
                if (md_left == 0) begin md_phase = PH_FREE; md_last = o; end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    int c0, c1, a0, w0, r0s;
    initial begin
        for (int n = 0; n < 2; n++) begin
            m_addr[n] = '0; m_page[n] = '0; m_read[n] = 0; m_write[n] = 0;
            m_wdata[n] = '0; m_be[n] = '0; m_bc[n] = '0;
        end
        s_wait = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_s_read", s_if.read, 0);
        chk("reset_s_write", s_if.write, 0);
        chk("reset_m0_wait", m_wait[0], 1);
        chk("reset_m1_wait", m_wait[1], 1);
        chk("reset_rdv", {m_rdv[0], m_rdv[1]}, 2'b00);
        chk("reset_last_grant", dbg_last_grant, 1);
        tick();
        rst = 1'b0;
        tick();

        // 1: m0 single read, page 2, address 0x10, data back after 3 cycles
        rsp_lat = 3; rsp_base = 64'hDEAD;
        c0 = rd_cnt[0]; c1 = rd_cnt[1]; a0 = s_rd_cycles;
        run_req(0, 1'b0, 16'h0010, 2'd2, 3'd1, 64'h0);
        wait_rd(0, c0 + 1);
        repeat (3) tick();
        chk("t1_rdv_count", rd_cnt[0] - c0, 1);
        chk("t1_rdata", last_rdata[0], 64'hDEAD);
        chk("t1_s_read_cycles", s_rd_cycles - a0, 1);
        chk("t1_page", last_rd_page, 2'd2);
        chk("t1_address", last_rd_addr, 16'h0010);
        chk("t1_m1_rdv", rd_cnt[1] - c1, 0);

        // 2: simultaneous single writes straight after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        w0 = wr_cyc_q.size();
        push_write(2'd1, 16'h0020, 1, 64'hA000);
        push_write(2'd3, 16'h0030, 1, 64'hB000);
        fork
            run_req(0, 1'b1, 16'h0020, 2'd1, 3'd1, 64'hA000);
            run_req(1, 1'b1, 16'h0030, 2'd3, 3'd1, 64'hB000);
        join
        tick();
        chk("t2_write_count", wr_cyc_q.size() - w0, 2);
        if (wr_cyc_q.size() - w0 == 2) chk("t2_bubble", wr_cyc_q[w0 + 1] - wr_cyc_q[w0], 2);
        chk("t2_last_grant", dbg_last_grant, 1);

        // 3: m1 4-beat write with m0 waiting; slave stalls beat 2 for 2 cycles
        w0 = s_wr_beats;
        push_write(2'd1, 16'h0040, 4, 64'hC000);
        push_write(2'd0, 16'h0050, 1, 64'hD000);
        fork
            run_req(1, 1'b1, 16'h0040, 2'd1, 3'd4, 64'hC000);
            begin tick(); run_req(0, 1'b1, 16'h0050, 2'd0, 3'd1, 64'hD000); end
            stall_after(w0 + 1, 2);
        join
        tick();
        chk("t3_beats", s_wr_beats - w0, 5);
        chk("t3_m0_after_burst", wr_cyc_q[$] - wr_cyc_q[$ - 1], 2);
        chk("t3_last_grant", dbg_last_grant, 0);

        // 4: m0 4-beat read while m1 wants to write
        rsp_lat = 2; rsp_base = 64'h1000;
        r0s = rd_cnt[0]; c1 = rd_cnt[1];
        push_write(2'd2, 16'h0080, 1, 64'hE000);
        fork
            run_req(0, 1'b0, 16'h0070, 2'd1, 3'd4, 64'h0);
            begin repeat (3) tick(); run_req(1, 1'b1, 16'h0080, 2'd2, 3'd1, 64'hE000); end
        join
        wait_rd(0, r0s + 4);
        tick();
        chk("t4_rdv_count", rd_cnt[0] - r0s, 4);
        chk("t4_last_rdata", last_rdata[0], 64'h1003);
        chk("t4_m1_rdv", rd_cnt[1] - c1, 0);
        chk("t4_m1_after_reads", wr_cyc_q[$] - last_rdv_cyc[0], 2);
        chk("t4_last_grant", dbg_last_grant, 1);

        // 5: reset during beat 2 of an m1 4-beat write
        push_write(2'd3, 16'h0090, 2, 64'hF000);
        m_addr[1] = 16'h0090; m_page[1] = 2'd3; m_bc[1] = 3'd4;
        m_be[1] = be_of(64'hF000); m_wdata[1] = 64'hF000; m_write[1] = 1'b1;
        tick();
        tick();
        m_wdata[1] = 64'hF001;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_write[1] = 1'b0;
        @(negedge clk);
        chk("t5_s_write", s_if.write, 0);
        chk("t5_m0_wait", m_wait[0], 1);
        chk("t5_m1_wait", m_wait[1], 1);
        chk("t5_last_grant", dbg_last_grant, 1);
        tick();
        push_write(2'd0, 16'h00A0, 1, 64'h5000);
        run_req(0, 1'b1, 16'h00A0, 2'd0, 3'd1, 64'h5000);
        tick();
        chk("t5_m0_granted", dbg_last_grant, 0);

        // 6: burstcount 0 read from m1, with a stray extra slave beat that must be dropped
        rsp_lat = 1; rsp_extra = 1; rsp_base = 64'h6000;
        c1 = rd_cnt[1]; c0 = rd_cnt[0];
        run_req(1, 1'b0, 16'h0060, 2'd3, 3'd0, 64'h0);
        wait_rd(1, c1 + 1);
        @(negedge clk);
        chk("t6_idle_after_one", dbg_state, 2'd0);
        repeat (3) tick();
        rsp_extra = 0;
        chk("t6_rdv_count", rd_cnt[1] - c1, 1);
        chk("t6_rdata", last_rdata[1], 64'h6000);
        chk("t6_m0_rdv", rd_cnt[0] - c0, 0);
        chk("t6_last_grant", dbg_last_grant, 1);

        repeat (2) tick();
        chk("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
